// File: rtl/pattern_generator.sv
// Serial pattern transmitter: captures 1..PAT_W bits on start and shifts them out MSB-first, DIV cycles per bit.
// First bit appears the cycle after start is accepted; stop aborts a run with no done pulse.
module pattern_generator #(
  parameter int PAT_W = 8,
  parameter int DIV   = 10000000,
  parameter int CNT_W = 24,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             repeat_en,
  output logic             ser_out,
  output logic             bit_stb,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bit_idx
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [PAT_W-1:0] pat_q, pat_nxt, pat_shift;
  logic [LEN_W-1:0] len_q, len_nxt, idx_nxt, len_eff, pos;
  logic             rep_q, rep_nxt, ser_nxt, stb_nxt, done_nxt;
  logic             accept, bit_end, last_bit;

  // Zero or oversize lengths fall back to the full pattern width.
  assign len_eff  = (len == '0 || len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
  assign accept   = (state == IDLE) && start && !stop;
  assign bit_end  = (cnt == CNT_W'(DIV - 1));
  assign last_bit = (bit_idx == len_q - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      rep_q   <= 1'b0;
      ser_out <= 1'b0;
      bit_stb <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pat_q   <= pat_nxt;
      len_q   <= len_nxt;
      rep_q   <= rep_nxt;
      ser_out <= ser_nxt;
      bit_stb <= stb_nxt;
      busy    <= (state_nxt == RUN);
      done    <= done_nxt;
      bit_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (stop || (bit_end && last_bit && !rep_q)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt  = '0;
    pat_nxt  = pat_q;
    len_nxt  = len_q;
    rep_nxt  = rep_q;
    idx_nxt  = '0;
    stb_nxt  = 1'b0;
    done_nxt = 1'b0;
    pos      = '0;
    if (accept) begin
      pat_nxt = pattern;
      len_nxt = len_eff;
      rep_nxt = repeat_en;
      pos     = len_eff - LEN_W'(1);
      stb_nxt = 1'b1;
    end else if (state == RUN && !stop) begin
      if (!bit_end) begin
        cnt_nxt = cnt + CNT_W'(1);
        idx_nxt = bit_idx;
        pos     = len_q - LEN_W'(1) - bit_idx;
      end else if (!last_bit) begin
        idx_nxt = bit_idx + LEN_W'(1);
        pos     = len_q - LEN_W'(2) - bit_idx;
        stb_nxt = 1'b1;
      end else begin
        // End of pass: wrap to the first bit when repeating, otherwise drop to IDLE.
        done_nxt = 1'b1;
        stb_nxt  = rep_q;
        pos      = len_q - LEN_W'(1);
      end
    end
    pat_shift = pat_nxt >> pos;
    ser_nxt   = (state_nxt == RUN) && pat_shift[0];
  end

endmodule

// File: tb/tb_pattern_generator.sv
// Bench for pattern_generator: directed and randomized runs on DIV=4 and DIV=1 instances, checked against a per-cycle timing model.
module tb_pattern_generator;

  typedef struct packed {
    logic       ser;
    logic       stb;
    logic       busy;
    logic       done;
    logic [3:0] idx;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0, stop = 1'b0, repeat_en = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic       ser_a, stb_a, busy_a, done_a, ser_b, stb_b, busy_b, done_b;
  logic [3:0] idx_a, idx_b;
  obs_t       obs_a, obs_b;
  int         n_chk = 0, n_pass = 0, n_fail = 0;

  always #5 clk = ~clk;

  pattern_generator #(.PAT_W(8), .DIV(4), .CNT_W(24), .LEN_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop), .pattern(pattern), .len(len),
    .repeat_en(repeat_en), .ser_out(ser_a), .bit_stb(stb_a), .busy(busy_a), .done(done_a),
    .bit_idx(idx_a));

  pattern_generator #(.PAT_W(8), .DIV(1), .CNT_W(24), .LEN_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop), .pattern(pattern), .len(len),
    .repeat_en(repeat_en), .ser_out(ser_b), .bit_stb(stb_b), .busy(busy_b), .done(done_b),
    .bit_idx(idx_b));

  assign obs_a = {ser_a, stb_a, busy_a, done_a, idx_a};
  assign obs_b = {ser_b, stb_b, busy_b, done_b, idx_b};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, int t, logic [31:0] o, logic [31:0] x);
    n_chk++;
    assert (o === x) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, o, x);
    end
  endtask

  task automatic chk_all(string tag, int t, obs_t o, obs_t x);
    chk({tag, ".ser"},  t, 32'(o.ser),  32'(x.ser));
    chk({tag, ".stb"},  t, 32'(o.stb),  32'(x.stb));
    chk({tag, ".busy"}, t, 32'(o.busy), 32'(x.busy));
    chk({tag, ".done"}, t, 32'(o.done), 32'(x.done));
    chk({tag, ".idx"},  t, 32'(o.idx),  32'(x.idx));
  endtask

  function automatic int eff_len(logic [3:0] l);
    return (l == 0 || l > 8) ? 8 : int'(l);
  endfunction

  // t counts edges since the start was sampled (t=1 shows the first bit); kill is the
  // observation time at which stop or rst was raised, so everything after it is idle.
  function automatic obs_t model(int t, logic [7:0] pat, int L, bit rep, int kill, int div);
    obs_t e;
    int p, ph, i;
    logic [7:0] sh;
    e = '0;
    if (kill > 0 && t > kill) return e;
    p  = (t - 1) / div;
    ph = (t - 1) % div;
    if (!rep && p >= L) begin
      e.done = (p == L && ph == 0);
      return e;
    end
    i      = p % L;
    sh     = pat >> (L - 1 - i);
    e.ser  = sh[0];
    e.stb  = (ph == 0);
    e.busy = 1'b1;
    e.idx  = 4'(i);
    e.done = (ph == 0) && (p > 0) && (i == 0);
    return e;
  endfunction

  task automatic run_case(string tag, int sel, logic [7:0] pat, logic [3:0] ln, bit rp,
                          int stop_t, int rst_t, bit perturb);
    int div, L, kill, n, lim;
    obs_t o;
    div  = sel ? 1 : 4;
    L    = eff_len(ln);
    kill = 0;
    if (stop_t > 0) kill = stop_t;
    if (rst_t > 0 && (kill == 0 || rst_t < kill)) kill = rst_t;
    n    = (kill > 0) ? kill + 1 : L * div + 1;
    lim  = (kill > 0) ? kill : L * div;
    pattern = pat; len = ln; repeat_en = rp; stop = 1'b0; rst = 1'b0;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    step();
    for (int t = 1; t <= n; t++) begin
      o = sel ? obs_b : obs_a;
      chk_all(tag, t, o, model(t, pat, L, rp, kill, div));
      if (t < n) begin
        start_a = 1'b0; start_b = 1'b0;
        stop = (t == stop_t);
        rst  = (t == rst_t);
        if (perturb) begin
          pattern   = 8'($urandom);
          len       = 4'($urandom);
          repeat_en = 1'($urandom);
          if (t < lim) begin
            if (sel) start_b = 1'($urandom); else start_a = 1'($urandom);
          end
        end
        step();
      end
    end
    start_a = 1'b0; start_b = 1'b0; stop = 1'b0; rst = 1'b0;
  endtask

  initial begin
    int sel, L, st, rt, g;
    logic [7:0] p;
    logic [3:0] ln;
    bit rp;

    // Reset held two cycles with start high: nothing may launch.
    rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
    step();
    chk_all("rst1", 1, obs_a, '0);
    step();
    chk_all("rst2", 2, obs_a, '0);
    chk_all("rst2b", 2, obs_b, '0);
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_all("post_rst", i, obs_a, '0);
    end

    run_case("single",  0, 8'h05, 4'd3, 1'b0, 0, 0, 1'b0);
    run_case("full",    0, 8'hA5, 4'd0, 1'b0, 0, 0, 1'b0);
    run_case("rep_stop", 0, 8'h02, 4'd3, 1'b1, 20, 0, 1'b0);
    run_case("rep_long", 0, 8'h02, 4'd3, 1'b1, 28, 0, 1'b0);
    run_case("ignore_rst", 0, 8'h05, 4'd3, 1'b0, 0, 7, 1'b1);
    run_case("div1",    1, 8'h15, 4'd5, 1'b0, 0, 0, 1'b0);
    run_case("len1",    0, 8'h01, 4'd1, 1'b0, 0, 0, 1'b0);
    run_case("restart", 0, 8'hC3, 4'd9, 1'b0, 0, 0, 1'b0);
    run_case("stop_last", 0, 8'h06, 4'd3, 1'b0, 12, 0, 1'b0);

    // Start and stop together in IDLE: stop wins.
    start_a = 1'b1; stop = 1'b1;
    step();
    chk_all("start_stop", 1, obs_a, '0);
    start_a = 1'b0; stop = 1'b0;

    for (int k = 0; k < 24; k++) begin
      sel = int'($urandom_range(0, 1));
      p   = 8'($urandom);
      ln  = 4'($urandom_range(0, 15));
      rp  = 1'($urandom_range(0, 1));
      L   = eff_len(ln);
      if (rp) st = int'($urandom_range(2, 3 * L * (sel ? 1 : 4)));
      else st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, L * (sel ? 1 : 4))) : 0;
      rt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, L * (sel ? 1 : 4))) : 0;
      run_case("rand", sel, p, ln, rp, st, rt, 1'b1);
      g = int'($urandom_range(0, 2));
      for (int i = 0; i < g; i++) begin
        step();
        chk_all("gap", i, sel ? obs_b : obs_a, '0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
